// File: rtl/esp32_prog_pkg.sv
// ---------------------------------------------------------------------------
// esp32_prog_pkg
// Shared definitions for the ESP32 programming sequencer:
//   - state_t      : FSM state encoding (also driven out on state_o for LEDs)
//   - P_*          : filtered {ndtr, nrts} pair codes of interest
//   - pins_t       : EN / GPIO0 request pair
//   - decode_pair  : maps a filtered pair to the EN / GPIO0 request
// ---------------------------------------------------------------------------
package esp32_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_STRAP = 3'd2,
        ST_PROG  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Filtered pair codes, bit 1 = ndtr, bit 0 = nrts.
    localparam logic [1:0] P_RESET = 2'b10;  // EN low, GPIO0 high
    localparam logic [1:0] P_BOOT  = 2'b01;  // EN high, GPIO0 low

    typedef struct packed {
        logic en;
        logic io0;
    } pins_t;

    // 00 and 11 both mean "released": EN high, GPIO0 high.
    function automatic pins_t decode_pair(input logic [1:0] p);
        pins_t r;
        r.en  = 1'b1;
        r.io0 = 1'b1;
        if (p == P_RESET) begin
            r.en = 1'b0;
        end else if (p == P_BOOT) begin
            r.io0 = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/esp32_prog_seq_pin_filter.sv
// ---------------------------------------------------------------------------
// pin_filter
// Two-flop synchroniser followed by a stability filter for a bundle of raw
// asynchronous pins. The filtered output takes the synchronised value only
// once that value has been unchanged for C_filter_cycles consecutive clocks;
// any change restarts the count. Everything resets to all-ones (pins idle).
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   i_raw   in   [C_width-1:0] raw pins, asynchronous to clk
//   o_filt  out  [C_width-1:0] synchronised, filtered pins (registered)
// ---------------------------------------------------------------------------
module pin_filter #(
    parameter int C_width         = 2,
    parameter int C_filter_cycles = 250   // must be >= 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [C_width-1:0] i_raw,
    output logic [C_width-1:0] o_filt
);

    localparam int C_CNT_W = $clog2(C_filter_cycles + 1);

    logic [C_width-1:0] w_sync;
    logic [C_width-1:0] r_sync_prev;
    logic [C_width-1:0] r_filt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < C_width; gi++) begin : g_sync
            logic r_meta;
            logic r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta <= 1'b1;
                    r_sync <= 1'b1;
                end else begin
                    r_meta <= i_raw[gi];
                    r_sync <= r_meta;
                end
            end
            assign w_sync[gi] = r_sync;
        end
    endgenerate

    // w_cnt_next = number of consecutive clocks (including this one) that
    // w_sync has held its present value, saturating at C_filter_cycles.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_sync != r_sync_prev) begin
            w_cnt_next = C_CNT_W'(1);
        end else if (r_cnt < C_CNT_W'(C_filter_cycles)) begin
            w_cnt_next = r_cnt + C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_prev <= '1;
            r_cnt       <= '0;
            r_filt      <= '1;
        end else begin
            r_sync_prev <= w_sync;
            r_cnt       <= w_cnt_next;
            if (w_cnt_next >= C_CNT_W'(C_filter_cycles)) begin
                r_filt <= w_sync;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/esp32_prog_seq.sv
// ---------------------------------------------------------------------------
// esp32_prog_seq
// Turns the FTDI DTR/RTS auto-program handshake (as toggled by esptool) plus a
// hold button into clean EN / GPIO0 requests for an ESP32, and tells the
// downstream pad logic when to drive the strapping pins.
//
// Ports:
//   clk_25mhz    in   sole clock
//   rst_n        in   asynchronous active-low reset
//   ftdi_ndtr    in   raw FTDI DTR (active-low, asynchronous)
//   ftdi_nrts    in   raw FTDI RTS (active-low, asynchronous)
//   btn_hold     in   synchronous level, 1 holds the ESP32 in reset
//   en_out       out  EN request, 1 = release, 0 = drive low
//   gpio0_out    out  GPIO0/GPIO2 strap value
//   prog_active  out  1 = drive strapping pins, 0 = tristate
//   state_o      out  [2:0] current state code
//
// All outputs are registered from the next-state decode, so they change on
// the same edge the state register does.
// ---------------------------------------------------------------------------
module esp32_prog_seq #(
    parameter int C_filter_cycles = 250,    // >= 1
    parameter int C_en_min_cycles = 25000,  // >= 1
    parameter int C_prog_timeout  = 26      // >= 1, MSB index of timeout counter
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic       ftdi_ndtr,
    input  logic       ftdi_nrts,
    input  logic       btn_hold,
    output logic       en_out,
    output logic       gpio0_out,
    output logic       prog_active,
    output logic [2:0] state_o
);

    import esp32_prog_pkg::*;

    localparam int C_PULSE_W = $clog2(C_en_min_cycles + 1);

    logic [1:0]              w_pair;
    pins_t                   w_dec;
    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_en;
    logic                    r_io0;
    logic                    r_prog_active;
    logic                    w_en_next;
    logic                    w_io0_next;
    logic                    w_prog_active_next;
    logic [C_PULSE_W-1:0]    r_pulse_cnt;
    logic [C_PULSE_W-1:0]    w_pulse_cnt_next;
    logic [C_prog_timeout:0] r_tmo_cnt;
    logic [C_prog_timeout:0] w_tmo_cnt_next;
    logic                    w_pulse_done;
    logic                    w_tmo_expire;
    logic                    w_enter_reset;

    pin_filter #(
        .C_width         (2),
        .C_filter_cycles (C_filter_cycles)
    ) u_pin_filter (
        .clk    (clk_25mhz),
        .rst_n  (rst_n),
        .i_raw  ({ftdi_ndtr, ftdi_nrts}),
        .o_filt (w_pair)
    );

    assign w_dec = decode_pair(w_pair);

    // Both checks look at the clock currently being completed, so EN is low
    // for exactly C_en_min_cycles clocks and the strapping window lasts
    // exactly 2^C_prog_timeout clocks from the RESET entry edge.
    assign w_pulse_done = (r_pulse_cnt >= C_PULSE_W'(C_en_min_cycles - 1));
    assign w_tmo_expire = r_tmo_cnt[C_prog_timeout] | (&r_tmo_cnt[C_prog_timeout-1:0]);

    // Next state. btn_hold overrides everything; a filtered 10 in PROG beats
    // a timeout expiring in the same cycle.
    always_comb begin
        w_state_next = r_state;
        if (btn_hold) begin
            w_state_next = ST_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pair == P_RESET) w_state_next = ST_RESET;
                end
                ST_RESET: begin
                    if (w_pair != P_RESET && w_pulse_done) begin
                        w_state_next = (w_pair == P_BOOT) ? ST_STRAP : ST_PROG;
                    end
                end
                ST_STRAP: begin
                    if (w_pair == P_RESET)     w_state_next = ST_RESET;
                    else if (w_pair != P_BOOT) w_state_next = ST_PROG;
                end
                ST_PROG: begin
                    if (w_pair == P_RESET)  w_state_next = ST_RESET;
                    else if (w_tmo_expire)  w_state_next = ST_IDLE;
                end
                ST_HOLD:  w_state_next = ST_RESET;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state.
    always_comb begin
        w_en_next          = 1'b1;
        w_io0_next         = 1'b1;
        w_prog_active_next = 1'b0;
        case (w_state_next)
            ST_IDLE: begin
                w_en_next  = w_dec.en;
                w_io0_next = w_dec.io0;
            end
            ST_RESET: begin
                w_en_next          = 1'b0;
                w_prog_active_next = 1'b1;
            end
            ST_STRAP: begin
                w_io0_next         = 1'b0;
                w_prog_active_next = 1'b1;
            end
            ST_PROG: begin
                w_en_next          = w_dec.en;
                w_io0_next         = w_dec.io0;
                w_prog_active_next = 1'b1;
            end
            ST_HOLD: begin
                w_en_next = 1'b0;
            end
            default: begin
                w_en_next = 1'b1;
            end
        endcase
    end

    // Counters restart on every edge that enters RESET, from whichever state.
    assign w_enter_reset = (w_state_next == ST_RESET) && (r_state != ST_RESET);

    always_comb begin
        w_pulse_cnt_next = r_pulse_cnt;
        w_tmo_cnt_next   = r_tmo_cnt;
        if (w_enter_reset) begin
            w_pulse_cnt_next = '0;
            w_tmo_cnt_next   = '0;
        end else begin
            if (r_state == ST_RESET && r_pulse_cnt < C_PULSE_W'(C_en_min_cycles)) begin
                w_pulse_cnt_next = r_pulse_cnt + C_PULSE_W'(1);
            end
            if ((r_state == ST_RESET || r_state == ST_STRAP || r_state == ST_PROG)
                && !r_tmo_cnt[C_prog_timeout]) begin
                w_tmo_cnt_next = r_tmo_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_en          <= 1'b1;
            r_io0         <= 1'b1;
            r_prog_active <= 1'b0;
            r_pulse_cnt   <= '0;
            r_tmo_cnt     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_en          <= w_en_next;
            r_io0         <= w_io0_next;
            r_prog_active <= w_prog_active_next;
            r_pulse_cnt   <= w_pulse_cnt_next;
            r_tmo_cnt     <= w_tmo_cnt_next;
        end
    end

    assign en_out      = r_en;
    assign gpio0_out   = r_io0;
    assign prog_active = r_prog_active;
    assign state_o     = r_state;

endmodule
